// File: rtl/wb_bus_scheduler.sv
// ---------------------------------------------------------------------------
// wb_bus_scheduler
//   Registered round-robin scheduler for a shared Wishbone bus with a single
//   slave path. It picks one owner among the masters that raise cyc. Each
//   grant carries a transfer quota that applies only while another master is
//   waiting. A stall watchdog releases a hung transaction and raises a
//   one-cycle bus error.
//
//   Every output comes straight from a register, so no combinational path
//   runs from the inputs to the grant.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   m_cyc_i_all    [M]   per-master cyc (the request)
//   m_stb_i_all    [M]   per-master stb
//   any_s_ack      OR of slave acks
//   any_s_err      OR of slave errs
//   any_s_rty      OR of slave rtys
//   grant_onehot   [M]   registered one-hot grant
//   grant_bin      [log2 M] binary grant index, 0 when idle
//   grant_valid    |grant_onehot
//   timeout_err    one-cycle pulse; the bus ORs it into the owner's err
//   quota_yield    one-cycle pulse when the quota revokes a grant
// ---------------------------------------------------------------------------
module wb_bus_scheduler #(
  parameter int M       = 4,
  parameter int MAX_TXN = 16,
  parameter int TIMEOUT = 256,
  parameter int CNTw    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [M-1:0]         m_cyc_i_all,
  input  logic [M-1:0]         m_stb_i_all,
  input  logic                 any_s_ack,
  input  logic                 any_s_err,
  input  logic                 any_s_rty,
  output logic [M-1:0]         grant_onehot,
  output logic [$clog2(M)-1:0] grant_bin,
  output logic                 grant_valid,
  output logic                 timeout_err,
  output logic                 quota_yield
);

  localparam int IW = $clog2(M);
  localparam bit QUOTA_ON = (MAX_TXN != 0);
  localparam logic [CNTw-1:0] WD_LAST = CNTw'(TIMEOUT - 1);
  localparam logic [CNTw-1:0] Q_LAST  = CNTw'((MAX_TXN == 0) ? 0 : MAX_TXN - 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  // Registered state
  state_t          r_state;
  logic [M-1:0]    r_grant;
  logic [IW-1:0]   r_bin;
  logic            r_gvalid;
  logic [IW-1:0]   r_ptr;
  logic [CNTw-1:0] r_qcnt;
  logic [CNTw-1:0] r_wd;
  logic            r_to;
  logic            r_qy;

  // Next-state values
  state_t          w_state_nxt;
  logic [M-1:0]    w_grant_nxt;
  logic [IW-1:0]   w_bin_nxt;
  logic [IW-1:0]   w_ptr_nxt;
  logic [CNTw-1:0] w_qcnt_nxt;
  logic [CNTw-1:0] w_wd_nxt;
  logic            w_to_nxt;
  logic            w_qy_nxt;

  // Bus status of the current owner
  logic w_g_cyc, w_g_stb, w_any_rsp, w_term, w_stall, w_pending;
  logic w_wd_fire, w_q_fire;

  // Round-robin search
  logic            w_found;
  logic [IW-1:0]   w_winner;
  logic [IW-1:0]   w_idx;

  assign w_g_cyc   = |(r_grant & m_cyc_i_all);
  assign w_g_stb   = |(r_grant & m_stb_i_all);
  assign w_any_rsp = any_s_ack | any_s_err | any_s_rty;
  assign w_term    = r_gvalid & w_g_cyc & w_g_stb & w_any_rsp;
  assign w_stall   = r_gvalid & w_g_cyc & w_g_stb & ~w_any_rsp;
  assign w_pending = |(m_cyc_i_all & ~r_grant);
  assign w_wd_fire = w_stall && (r_wd == WD_LAST);
  assign w_q_fire  = QUOTA_ON && w_term && (r_qcnt == Q_LAST) && w_pending;

  // Search upward from the master after the last winner. The last winner is
  // checked last, so it wins again only when no other master is requesting.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= M; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % M);
      if (!w_found && m_cyc_i_all[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // NOTE: every signal this block writes gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_bin_nxt   = r_bin;
    w_ptr_nxt   = r_ptr;
    w_qcnt_nxt  = r_qcnt;
    w_wd_nxt    = r_wd;
    w_to_nxt    = 1'b0;
    w_qy_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_grant_nxt = '0;
        w_bin_nxt   = '0;
        if (w_found) begin
          w_grant_nxt = {{(M-1){1'b0}}, 1'b1} << w_winner;
          w_bin_nxt   = w_winner;
          w_ptr_nxt   = w_winner;
          w_qcnt_nxt  = '0;
          w_wd_nxt    = '0;
          w_state_nxt = S_OWN;
        end
      end

      S_OWN: begin
        // The watchdog takes priority over a cyc drop. A cyc drop takes
        // priority over quota expiry.
        if (w_wd_fire || !w_g_cyc || w_q_fire) begin
          w_to_nxt    = w_wd_fire;
          w_qy_nxt    = !w_wd_fire && w_g_cyc && w_q_fire;
          w_grant_nxt = '0;
          w_bin_nxt   = '0;
          w_qcnt_nxt  = '0;
          w_wd_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else begin
          // The count saturates at the last slot. It expires only on a
          // termination that happens while another master is waiting.
          if (QUOTA_ON && w_term && (r_qcnt != Q_LAST))
            w_qcnt_nxt = r_qcnt + 1'b1;
          w_wd_nxt = w_stall ? r_wd + 1'b1 : '0;
        end
      end

      default: begin
        w_grant_nxt = '0;
        w_bin_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples its inputs at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_bin    <= '0;
      r_gvalid <= 1'b0;
      r_ptr    <= IW'(M - 1);
      r_qcnt   <= '0;
      r_wd     <= '0;
      r_to     <= 1'b0;
      r_qy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_bin    <= w_bin_nxt;
      r_gvalid <= |w_grant_nxt;
      r_ptr    <= w_ptr_nxt;
      r_qcnt   <= w_qcnt_nxt;
      r_wd     <= w_wd_nxt;
      r_to     <= w_to_nxt;
      r_qy     <= w_qy_nxt;
    end
  end

  assign grant_onehot = r_grant;
  assign grant_bin    = r_bin;
  assign grant_valid  = r_gvalid;
  assign timeout_err  = r_to;
  assign quota_yield  = r_qy;

endmodule
